// File: rtl/riscv_trace_buffer_if.sv
// Bus between the single-cycle core's debug outputs, the trace buffer and
// the trace consumer. The master side is the core plus consumer, and the
// slave side is the trace buffer itself.
interface riscv_trace_buffer_if #(
    parameter int DEPTH = 16,
    parameter int CW    = 32
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    // Core retirement outputs
    logic            trace_en;
    logic [63:0]     PC_Out;
    logic [31:0]     Instruction;
    logic            RegWrite;
    logic [4:0]      rd;
    logic [63:0]     WriteData;
    logic            MemWrite;
    logic [63:0]     Result;
    logic [63:0]     ReadData2;

    // Consumer handshake and head entry
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_cycle;
    logic [63:0]     out_pc;
    logic [31:0]     out_instr;
    logic            out_wb;
    logic [4:0]      out_rd;
    logic [63:0]     out_wdata;
    logic            out_st;
    logic [63:0]     out_addr;
    logic [63:0]     out_sdata;

    // Status
    logic [CNTW-1:0] count;
    logic [15:0]     dropped;
    logic            halted;

    modport master (
        output trace_en, PC_Out, Instruction, RegWrite, rd, WriteData,
               MemWrite, Result, ReadData2, out_ready,
        input  out_valid, out_cycle, out_pc, out_instr, out_wb, out_rd,
               out_wdata, out_st, out_addr, out_sdata, count, dropped, halted
    );

    modport slave (
        input  trace_en, PC_Out, Instruction, RegWrite, rd, WriteData,
               MemWrite, Result, ReadData2, out_ready,
        output out_valid, out_cycle, out_pc, out_instr, out_wb, out_rd,
               out_wdata, out_st, out_addr, out_sdata, count, dropped, halted
    );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Retirement trace capture FIFO for the single-cycle RISC-V core.
// Each edge records the executing instruction and stamps it with a free-running
// cycle counter. It also detects a "jal x0,0" self-loop halt and counts the
// captures lost to overflow.
module riscv_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_trace_buffer_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    typedef struct packed {
        logic [CW-1:0] cycle;
        logic [63:0]   pc;
        logic [31:0]   instr;
        logic          wb;
        logic [4:0]    rd;
        logic [63:0]   wdata;
        logic          st;
        logic [63:0]   addr;
        logic [63:0]   sdata;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic [15:0]     r_dropped;
    logic [CW-1:0]   r_cycle;
    logic [63:0]     r_prev_pc;
    logic            r_prev_ok;
    logic            r_halted;

    logic            w_full;
    logic            w_valid;
    logic            w_pop;
    logic            w_detect;
    logic            w_capture;
    logic            w_push;
    logic            w_drop;
    entry_t          w_new;
    entry_t          w_head;

    // Handshake, halt detection and push/drop decisions for this edge
    always_comb begin
        w_full    = (r_count == CNTW'(DEPTH));
        w_valid   = (r_count != '0);
        w_pop     = w_valid && bus.out_ready;
        w_detect  = r_prev_ok && !r_halted && (bus.PC_Out == r_prev_pc)
                    && (bus.Instruction == 32'h0000_006F);
        w_capture = bus.trace_en && !r_halted && !reset;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        w_push    = w_capture && !w_detect && (!w_full || w_pop);
        w_drop    = w_capture && !w_detect && w_full && !w_pop;
    end

    // Build the entry to store, zeroing fields that do not apply
    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        w_new       = '0;
        w_new.cycle = r_cycle;
        w_new.pc    = bus.PC_Out;
        w_new.instr = bus.Instruction;
        if (bus.RegWrite && (bus.rd != 5'd0)) begin
            w_new.wb    = 1'b1;
            w_new.rd    = bus.rd;
            w_new.wdata = bus.WriteData;
        end
        if (bus.MemWrite) begin
            w_new.st    = 1'b1;
            w_new.addr  = bus.Result;
            w_new.sdata = bus.ReadData2;
        end
    end

    // Entry storage write port
    // NOTE: storage is deliberately not reset; out_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    // Pointers, occupancy, drop counter, cycle stamp and halt tracking
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= '0;
            r_cycle   <= '0;
            r_prev_pc <= '0;
            r_prev_ok <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_cycle   <= r_cycle + CW'(1);
            r_prev_pc <= bus.PC_Out;
            r_prev_ok <= 1'b1;
            if (w_detect) begin
                r_halted <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    // Head entry presented to the consumer; all-zero while the FIFO is empty
    always_comb begin
        w_head = w_valid ? r_mem[r_rd_ptr] : '0;
    end

    assign bus.out_valid = w_valid;
    assign bus.out_cycle = w_head.cycle;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_instr = w_head.instr;
    assign bus.out_wb    = w_head.wb;
    assign bus.out_rd    = w_head.rd;
    assign bus.out_wdata = w_head.wdata;
    assign bus.out_st    = w_head.st;
    assign bus.out_addr  = w_head.addr;
    assign bus.out_sdata = w_head.sdata;
    assign bus.count     = r_count;
    assign bus.dropped   = r_dropped;
    assign bus.halted    = r_halted;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer: in-order drain, field masking,
// overflow, self-loop halt, mid-run reset and the empty push/pop corner.
module tb_riscv_trace_buffer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    riscv_trace_buffer_if #(.DEPTH(16), .CW(32)) bus ();

    riscv_trace_buffer #(.DEPTH(16), .CW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop in case the run stalls
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop(input logic [63:0] pc);
        bus.PC_Out      = pc;
        bus.Instruction = 32'h0000_0013;
        bus.RegWrite    = 1'b0;
        bus.rd          = 5'd0;
        bus.WriteData   = '0;
        bus.MemWrite    = 1'b0;
        bus.Result      = '0;
        bus.ReadData2   = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.trace_en  = 1'b0;
        bus.out_ready = 1'b0;
        drive_nop(64'h0);
        tick();
        tick();

        // Reset state
        check("rst_valid",   bus.out_valid, 0);
        check("rst_count",   bus.count, 0);
        check("rst_dropped", bus.dropped, 0);
        check("rst_halted",  bus.halted, 0);
        check("rst_pc",      bus.out_pc, 0);

        // Five captures, PCs 0..16, stamps 0..4
        reset = 1'b0;
        bus.trace_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_nop(64'(4 * i));
            tick();
        end
        bus.trace_en = 1'b0;
        check("five_count", bus.count, 5);
        check("five_valid", bus.out_valid, 1);
        check("five_pc",    bus.out_pc, 0);
        check("five_cycle", bus.out_cycle, 0);

        // Drain in order (edges with stamps 5..9)
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_pc",    bus.out_pc, 64'(4 * i));
            check("drain_cycle", bus.out_cycle, 64'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        check("drain_valid", bus.out_valid, 0);
        check("drain_pc0",   bus.out_pc, 0);

        // addi x5,x0,7 at stamp 10; same with rd=0; sd
        bus.trace_en = 1'b1;
        drive_nop(64'h100);
        bus.Instruction = 32'h0070_0293;
        bus.RegWrite = 1'b1; bus.rd = 5'd5; bus.WriteData = 64'd7;
        tick();
        drive_nop(64'h104);
        bus.Instruction = 32'h0070_0013;
        bus.RegWrite = 1'b1; bus.rd = 5'd0; bus.WriteData = 64'd7;
        tick();
        drive_nop(64'h108);
        bus.Instruction = 32'h00b5_3023;
        bus.MemWrite = 1'b1; bus.Result = 64'h20; bus.ReadData2 = 64'hDEAD;
        tick();
        bus.trace_en = 1'b0;
        drive_nop(64'h10c);
        check("addi_cycle", bus.out_cycle, 10);
        check("addi_wb",    bus.out_wb, 1);
        check("addi_rd",    bus.out_rd, 5);
        check("addi_wdata", bus.out_wdata, 7);
        check("addi_st",    bus.out_st, 0);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        check("x0_pc",    bus.out_pc, 64'h104);
        check("x0_wb",    bus.out_wb, 0);
        check("x0_rd",    bus.out_rd, 0);
        check("x0_wdata", bus.out_wdata, 0);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        check("sd_st",    bus.out_st, 1);
        check("sd_addr",  bus.out_addr, 64'h20);
        check("sd_sdata", bus.out_sdata, 64'hDEAD);
        check("sd_wb",    bus.out_wb, 0);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        check("sd_drained", bus.count, 0);

        // Overflow: 20 captures into 16 entries
        bus.trace_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_nop(64'h200 + 64'(4 * i));
            tick();
        end
        check("ovf_count",   bus.count, 16);
        check("ovf_dropped", bus.dropped, 4);
        check("ovf_head",    bus.out_pc, 64'h200);

        // Full with simultaneous push and pop: nothing lost
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_nop(64'h300 + 64'(4 * i));
            tick();
            check("full_pp_count",   bus.count, 16);
            check("full_pp_dropped", bus.dropped, 4);
        end
        check("full_pp_head", bus.out_pc, 64'h210);
        bus.trace_en = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        bus.out_ready = 1'b0;
        check("ovf_drained", bus.count, 0);

        // Six ordinary captures, then a self-loop at 0x40 held for 3 cycles
        bus.trace_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_nop(64'h400 + 64'(4 * i));
            tick();
        end
        drive_nop(64'h40);
        bus.Instruction = 32'h0000_006F;
        tick();
        check("loop1_count",  bus.count, 7);
        check("loop1_halted", bus.halted, 0);
        tick();
        check("loop2_count",  bus.count, 7);
        check("loop2_halted", bus.halted, 1);
        tick();
        check("loop3_count",  bus.count, 7);
        drive_nop(64'h500);
        tick();
        check("halt_nopush", bus.count, 7);
        check("halt_sticky", bus.halted, 1);

        // Reset pulse with 7 entries held and halted set
        bus.trace_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count",   bus.count, 0);
        check("mid_rst_valid",   bus.out_valid, 0);
        check("mid_rst_dropped", bus.dropped, 0);
        check("mid_rst_halted",  bus.halted, 0);
        check("mid_rst_pc",      bus.out_pc, 0);
        bus.trace_en = 1'b1;
        drive_nop(64'h500);
        tick();
        bus.trace_en = 1'b0;
        check("post_rst_cycle", bus.out_cycle, 0);
        check("post_rst_pc",    bus.out_pc, 64'h500);

        // Empty FIFO: push and ready together; the pop is ignored
        bus.out_ready = 1'b1;
        tick();
        check("empty_before", bus.count, 0);
        bus.trace_en = 1'b1;
        drive_nop(64'h600);
        tick();
        bus.trace_en = 1'b0;
        bus.out_ready = 1'b0;
        check("empty_pp_valid", bus.out_valid, 1);
        check("empty_pp_count", bus.count, 1);
        check("empty_pp_pc",    bus.out_pc, 64'h600);
        tick();
        check("stall_pc",    bus.out_pc, 64'h600);
        check("stall_cycle", bus.out_cycle, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
